// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between core (C) and DMA (D).
// Optional DMA bus lock enabled by defining RAM_ARB_LOCK_EN.
module data_ram_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic [DW/8-1:0] c_be,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic          d_lock,
`endif
  output logic          ram_en,
  output logic          ram_we,
  output logic [DW/8-1:0] ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic r_last_owner;
  logic r_rd_valid;
  logic r_rd_owner;
  logic w_c_win;
  logic w_d_win;
  logic w_lock_active;
  logic w_sel_we;

`ifdef RAM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    ST_ARB,
    ST_LOCK
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_lock_cnt;
  logic [CW-1:0]  w_lock_cnt_nxt;
  logic           w_force_exit;

  assign w_lock_active = (r_state == ST_LOCK);

  // Lock state and locked-cycle counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_ARB;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // Lock entry on a locked DMA grant; exit on release or when the budget is used
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_force_exit   = 1'b0;
    unique case (r_state)
      ST_ARB: begin
        if (w_d_win && d_lock) begin
          w_state_nxt    = ST_LOCK;
          w_lock_cnt_nxt = CW'(1);
        end
      end
      ST_LOCK: begin
        w_lock_cnt_nxt = r_lock_cnt + CW'(1);
        if (!d_lock) begin
          w_state_nxt    = ST_ARB;
          w_lock_cnt_nxt = '0;
        end else if (w_lock_cnt_nxt >= CW'(LOCK_MAX)) begin
          w_state_nxt    = ST_ARB;
          w_lock_cnt_nxt = '0;
          w_force_exit   = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = ST_ARB;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end
`else
  assign w_lock_active = 1'b0;
`endif

  // Pick the winner: lone requester wins, conflicts go to whoever did not own last
  always_comb begin
    w_c_win = 1'b0;
    w_d_win = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        w_lock_active: w_d_win = d_req;
        (c_req && d_req): begin
          w_c_win = (r_last_owner == OWN_D);
          w_d_win = (r_last_owner == OWN_C);
        end
        default: begin
          w_c_win = c_req;
          w_d_win = d_req;
        end
      endcase
    end
  end

  assign c_gnt = w_c_win;
  assign d_gnt = w_d_win;

  // Steer the winning request onto the RAM port
  always_comb begin
    w_sel_we  = w_d_win ? d_we : c_we;
    ram_en    = w_c_win | w_d_win;
    ram_we    = ram_en & w_sel_we;
    ram_addr  = w_d_win ? d_addr : c_addr;
    ram_wdata = w_d_win ? d_wdata : c_wdata;
    ram_be    = '0;
    if (ram_we) begin
      ram_be = w_d_win ? d_be : c_be;
    end
  end

  // Track last owner and tag each issued read with its requester
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_owner <= OWN_D;
      r_rd_valid   <= 1'b0;
      r_rd_owner   <= OWN_C;
    end else begin
      r_rd_valid <= ram_en & ~ram_we;
      r_rd_owner <= w_d_win ? OWN_D : OWN_C;
      if (ram_en) begin
        r_last_owner <= w_d_win ? OWN_D : OWN_C;
      end
`ifdef RAM_ARB_LOCK_EN
      if (w_force_exit) begin
        r_last_owner <= OWN_D;
      end
`endif
    end
  end

  assign c_rvalid = r_rd_valid & (r_rd_owner == OWN_C);
  assign d_rvalid = r_rd_valid & (r_rd_owner == OWN_D);
  assign c_rdata  = ram_rdata;
  assign d_rdata  = ram_rdata;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed scenarios plus
// randomized traffic against a behavioural grant/memory model.
module tb_data_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int LOCK_MAX = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic [BW-1:0] c_be, d_be;
  logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] c_rdata, d_rdata;
`ifdef RAM_ARB_LOCK_EN
  logic          d_lock = 1'b0;
`endif
  logic          ram_en, ram_we;
  logic [BW-1:0] ram_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem  [2**AW];
  logic [DW-1:0] gold [2**AW];
  logic [DW-1:0] ram_tmp;
  logic          exp_last;

  always #5 clock = ~clock;

  data_ram_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_be(c_be),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef RAM_ARB_LOCK_EN
    .d_lock(d_lock),
`endif
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // single-port RAM with one-cycle read latency
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_tmp = mem[ram_addr];
        for (int b = 0; b < BW; b++)
          if (ram_be[b]) ram_tmp[8*b +: 8] = ram_wdata[8*b +: 8];
        mem[ram_addr] <= ram_tmp;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic idle();
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_be = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
`ifdef RAM_ARB_LOCK_EN
    d_lock = 0;
`endif
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    next();
    reset = 0;
    exp_last = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    c_req = 1; c_addr = 10'd5;
    @(negedge clock);
    n_assert++;
    if ({c_gnt, d_gnt, ram_en, c_rvalid, d_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {c_gnt, d_gnt, ram_en, c_rvalid, d_rvalid});
    end
    next();
    reset = 0;
    exp_last = 1'b1;
    @(negedge clock);
    n_assert++;
    if ({c_gnt, d_gnt, ram_en, ram_we, ram_addr, ram_be} !==
        {4'b1010, 10'd5, 4'h0}) begin
      n_fail++;
      $display("FAIL first_read_grant: got gnt=%b%b en=%b we=%b a=%0d be=%h expected 1 0 1 0 5 0",
               c_gnt, d_gnt, ram_en, ram_we, ram_addr, ram_be);
    end
    next();
    idle();
    exp_last = 1'b0;
    @(negedge clock);
    n_assert++;
    if ({c_rvalid, d_rvalid, c_rdata} !== {2'b10, 32'd100}) begin
      n_fail++;
      $display("FAIL first_read_data: got rv=%b%b data=%0d expected 10 100",
               c_rvalid, d_rvalid, c_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] prev;
    logic [1:0] exp_g;
    do_reset();
    c_req = 1; c_addr = 10'd11;
    d_req = 1; d_addr = 10'd22;
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clock);
      n_assert++;
      if ({c_gnt, d_gnt} !== exp_g) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", i, {c_gnt, d_gnt}, exp_g);
      end
      n_assert++;
      if ({c_rvalid, d_rvalid} !== prev) begin
        n_fail++;
        $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, {c_rvalid, d_rvalid}, prev);
      end
      prev = exp_g;
      next();
    end
    idle();
    exp_last = 1'b1;
  endtask

  task automatic test_write_then_read();
    do_reset();
    c_req = 1; c_we = 1; c_addr = 10'd0; c_wdata = 32'd100; c_be = 4'hF;
    d_req = 1; d_we = 0; d_addr = 10'd0;
    @(negedge clock);
    n_assert++;
    if ({c_gnt, d_gnt, ram_we, ram_be, ram_wdata} !== {3'b101, 4'hF, 32'd100}) begin
      n_fail++;
      $display("FAIL wr_first: got gnt=%b%b we=%b be=%h wd=%0d expected 10 1 f 100",
               c_gnt, d_gnt, ram_we, ram_be, ram_wdata);
    end
    gold[0] = 32'd100;
    next();
    c_req = 0; c_we = 0;
    @(negedge clock);
    n_assert++;
    if ({c_gnt, d_gnt, ram_we} !== 3'b010) begin
      n_fail++;
      $display("FAIL rd_second: got gnt=%b%b we=%b expected 01 0", c_gnt, d_gnt, ram_we);
    end
    next();
    idle();
    @(negedge clock);
    n_assert++;
    if ({c_rvalid, d_rvalid, d_rdata} !== {2'b01, 32'd100}) begin
      n_fail++;
      $display("FAIL rd_after_wr: got rv=%b%b data=%0d expected 01 100",
               c_rvalid, d_rvalid, d_rdata);
    end
    exp_last = 1'b1;
  endtask

  task automatic test_back_to_back();
    idle();
    d_req = 1; d_addr = 10'd7;
    @(negedge clock);
    n_assert++;
    if ({c_gnt, d_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_dgnt: got %b expected 01", {c_gnt, d_gnt});
    end
    next();
    d_req = 0;
    c_req = 1; c_addr = 10'd8;
    @(negedge clock);
    n_assert++;
    if ({c_gnt, c_rvalid, d_rvalid, d_rdata} !== {3'b101, gold[7]}) begin
      n_fail++;
      $display("FAIL b2b_d_data: got gnt=%b rv=%b%b data=%h expected 1 01 %h",
               c_gnt, c_rvalid, d_rvalid, d_rdata, gold[7]);
    end
    next();
    idle();
    @(negedge clock);
    n_assert++;
    if ({c_rvalid, d_rvalid, c_rdata} !== {2'b10, gold[8]}) begin
      n_fail++;
      $display("FAIL b2b_c_data: got rv=%b%b data=%h expected 10 %h",
               c_rvalid, d_rvalid, c_rdata, gold[8]);
    end
    next();
    @(negedge clock);
    n_assert++;
    if ({c_rvalid, d_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_quiet: got %b expected 00", {c_rvalid, d_rvalid});
    end
    exp_last = 1'b0;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    c_req = 1; c_addr = 10'd5;
    @(negedge clock);
    n_assert++;
    if (c_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_gnt: got %b expected 1", c_gnt);
    end
    next();
    reset = 1;
    idle();
    @(negedge clock);
    n_assert++;
    if ({c_rvalid, d_rvalid, ram_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL inflight_drop: got rv=%b%b en=%b expected 00 0",
               c_rvalid, d_rvalid, ram_en);
    end
    next();
    reset = 0;
    exp_last = 1'b1;
    c_req = 1; c_addr = 10'd3;
    d_req = 1; d_addr = 10'd4;
    @(negedge clock);
    n_assert++;
    if ({c_gnt, d_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_conflict: got %b expected 10", {c_gnt, d_gnt});
    end
    next();
    idle();
    @(negedge clock);
    n_assert++;
    if ({c_rvalid, d_rvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset_rvalid: got %b expected 10", {c_rvalid, d_rvalid});
    end
    exp_last = 1'b0;
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    c_req = 1; c_addr = 10'd1;
    d_req = 1; d_addr = 10'd2; d_lock = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      n_assert++;
      if ({c_gnt, d_gnt} !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL lock_grant[%0d]: got %b expected %b", i, {c_gnt, d_gnt}, exp_seq[i]);
      end
      next();
    end
    idle();
    next();
    next();
  endtask
`endif

  task automatic test_random();
    logic pc, pd, ewc, ewd, ewe;
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd_data;
    logic [BW-1:0] ebe;
    do_reset();
    pc = 0; pd = 0;
    exp_rv = 2'b00;
    exp_rd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pc && $urandom_range(0, 1) == 1) begin
        pc = 1;
        c_we = 1'($urandom_range(0, 1));
        c_addr = AW'($urandom_range(0, 7));
        c_wdata = $urandom;
        c_be = BW'($urandom_range(0, 15));
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 7));
        d_wdata = $urandom;
        d_be = BW'($urandom_range(0, 15));
      end
      c_req = pc;
      d_req = pd;
      @(negedge clock);
      ewc = pc && (!pd || exp_last);
      ewd = pd && !ewc;
      n_assert++;
      if ({c_gnt, d_gnt} !== {ewc, ewd}) begin
        n_fail++;
        $display("FAIL rnd_grant[%0d]: got %b expected %b", i, {c_gnt, d_gnt}, {ewc, ewd});
      end
      n_assert++;
      if ({c_rvalid, d_rvalid} !== exp_rv) begin
        n_fail++;
        $display("FAIL rnd_rvalid[%0d]: got %b expected %b", i, {c_rvalid, d_rvalid}, exp_rv);
      end
      if (exp_rv != 2'b00) begin
        n_assert++;
        if ((exp_rv[1] ? c_rdata : d_rdata) !== exp_rd) begin
          n_fail++;
          $display("FAIL rnd_rdata[%0d]: got %h expected %h", i,
                   exp_rv[1] ? c_rdata : d_rdata, exp_rd);
        end
      end
      exp_rv = 2'b00;
      if (ewc || ewd) begin
        ewe = ewc ? c_we : d_we;
        ea = ewc ? c_addr : d_addr;
        ewd_data = ewc ? c_wdata : d_wdata;
        ebe = ewe ? (ewc ? c_be : d_be) : '0;
        n_assert++;
        if ({ram_en, ram_we, ram_addr, ram_be} !== {1'b1, ewe, ea, ebe}) begin
          n_fail++;
          $display("FAIL rnd_ram[%0d]: got en=%b we=%b a=%0d be=%h expected 1 %b %0d %h",
                   i, ram_en, ram_we, ram_addr, ram_be, ewe, ea, ebe);
        end
        if (ewe) begin
          n_assert++;
          if (ram_wdata !== ewd_data) begin
            n_fail++;
            $display("FAIL rnd_wdata[%0d]: got %h expected %h", i, ram_wdata, ewd_data);
          end
          for (int b = 0; b < BW; b++)
            if (ebe[b]) gold[ea][8*b +: 8] = ewd_data[8*b +: 8];
        end else begin
          exp_rv = ewc ? 2'b10 : 2'b01;
          exp_rd = gold[ea];
        end
        exp_last = ewd;
        if (ewc) pc = 0;
        if (ewd) pd = 0;
      end else begin
        n_assert++;
        if (ram_en !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_idle_en[%0d]: got %b expected 0", i, ram_en);
        end
      end
      next();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]  = DW'(i * 3 + 7);
      gold[i] = DW'(i * 3 + 7);
    end
    mem[5]  = 32'd100;
    gold[5] = 32'd100;
    exp_last = 1'b1;
    test_reset();
    test_round_robin();
    test_write_then_read();
    test_back_to_back();
    test_reset_inflight();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
